// File: rtl/lut_reverse_search.sv
// Reverse lookup of an 8-bit value into the 3-bit index of a constant
// 8-entry table. The table is scanned one entry per clock. The lowest
// matching index is reported, or a miss (hit=0, index=0) if no entry matches.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request; in_ready high
// SEARCH  | compare table[scan] with the captured value, one per cycle
// DONE    | result presented on out_*; wait for out_ready
module lut_reverse_search #(
    parameter bit SEARCH_ALL = 1'b0   // 1: always scan all 8 entries (fixed latency)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_value,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_hit,
    output logic [2:0] out_index,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_value;
    logic [2:0] r_scan;
    logic       r_hit;
    logic [2:0] r_index;

    logic [7:0] w_entry;
    logic       w_match;
    logic       w_last;
    logic       w_accept;

    // Constant table contents; entries 4..7 duplicate entry 0 on purpose,
    // which is why the first match has to win.
    function automatic logic [7:0] lut_entry(input logic [2:0] idx);
        logic [7:0] val;
        case (idx)
            3'd0:    val = 8'h00;
            3'd1:    val = 8'h01;
            3'd2:    val = 8'h1E;
            3'd3:    val = 8'hE2;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

    assign w_entry  = lut_entry(r_scan);
    assign w_match  = (w_entry == r_value);
    assign w_last   = (r_scan == 3'd7);
    assign w_accept = (r_state == S_IDLE) && in_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; the compare at index 7 always leaves SEARCH,
    // so the scan counter never wraps while searching.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (w_last || (!SEARCH_ALL && w_match)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request capture, scan counter and first-match recording
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= 8'h00;
            r_scan  <= 3'd0;
            r_hit   <= 1'b0;
            r_index <= 3'd0;
        end else if (w_accept) begin
            r_value <= in_value;
            r_scan  <= 3'd0;
            r_hit   <= 1'b0;
            r_index <= 3'd0;
        end else if (r_state == S_SEARCH) begin
            r_scan <= r_scan + 3'd1;
            if (w_match && !r_hit) begin
                r_hit   <= 1'b1;
                r_index <= r_scan;
            end
        end
    end

    // Outputs decoded from state; the result registers only change on
    // accept or during SEARCH, so they hold steady throughout DONE.
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        out_valid = (r_state == S_DONE);
        out_hit   = r_hit;
        out_index = r_index;
    end

endmodule

// File: tb/tb_lut_reverse_search.sv
// Directed bench for lut_reverse_search: one instance per SEARCH_ALL
// setting, hand-computed expected latency and result for each request.
module tb_lut_reverse_search;

    logic       clk;
    logic       rst_n;

    logic       in_valid0, in_valid1;
    logic [7:0] in_value0, in_value1;
    logic       out_ready0, out_ready1;
    logic       in_ready0, in_ready1;
    logic       out_valid0, out_valid1;
    logic       out_hit0, out_hit1;
    logic [2:0] out_index0, out_index1;
    logic       busy0, busy1;

    bit         sel;
    logic       o_ready, o_valid, o_hit, o_busy;
    logic [2:0] o_index;

    int         n_total;
    int         n_bad;

    lut_reverse_search #(.SEARCH_ALL(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_value(in_value0), .in_ready(in_ready0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_hit(out_hit0), .out_index(out_index0), .busy(busy0)
    );

    lut_reverse_search #(.SEARCH_ALL(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_value(in_value1), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_hit(out_hit1), .out_index(out_index1), .busy(busy1)
    );

    assign o_ready = sel ? in_ready1  : in_ready0;
    assign o_valid = sel ? out_valid1 : out_valid0;
    assign o_hit   = sel ? out_hit1   : out_hit0;
    assign o_index = sel ? out_index1 : out_index0;
    assign o_busy  = sel ? busy1      : busy0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_req(input bit s, input logic v, input logic [7:0] val);
        if (s) begin
            in_valid1 = v;
            in_value1 = val;
        end else begin
            in_valid0 = v;
            in_value0 = val;
        end
    endtask

    task automatic drive_ordy(input bit s, input logic v);
        if (s) out_ready1 = v;
        else   out_ready0 = v;
    endtask

    // One request: accept, wait for the result with a cycle budget, hold it
    // for 'hold' cycles with out_ready low, then transfer it. During the
    // search in_valid stays high with a different value, which must be ignored.
    task automatic run_req(input bit s, input logic [7:0] v, input logic eh,
                           input logic [2:0] ei, input int elat, input int hold);
        int cyc;
        @(negedge clk);
        sel = s;
        drive_req(s, 1'b1, v);
        #1;
        check_val("ready_before_accept", {31'd0, o_ready}, 32'd1);
        @(posedge clk);
        #1;
        drive_req(s, 1'b1, ~v);
        check_val("busy_after_accept", {31'd0, o_busy}, 32'd1);
        check_val("ready_after_accept", {31'd0, o_ready}, 32'd0);
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (o_valid) break;
            check_val("busy_in_search", {31'd0, o_busy}, 32'd1);
        end
        check_val("latency", cyc, elat);
        check_val("hit", {31'd0, o_hit}, {31'd0, eh});
        check_val("index", {29'd0, o_index}, {29'd0, ei});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_val("hold_valid", {31'd0, o_valid}, 32'd1);
            check_val("hold_hit", {31'd0, o_hit}, {31'd0, eh});
            check_val("hold_index", {29'd0, o_index}, {29'd0, ei});
            check_val("hold_ready", {31'd0, o_ready}, 32'd0);
            check_val("hold_busy", {31'd0, o_busy}, 32'd1);
        end
        drive_ordy(s, 1'b1);
        @(posedge clk);
        #1;
        drive_ordy(s, 1'b0);
        drive_req(s, 1'b0, 8'h00);
        check_val("post_xfer_valid", {31'd0, o_valid}, 32'd0);
        check_val("post_xfer_ready", {31'd0, o_ready}, 32'd1);
        check_val("post_xfer_busy", {31'd0, o_busy}, 32'd0);
    endtask

    logic [7:0] b2b_val [3];
    logic       b2b_hit [3];
    logic [2:0] b2b_idx [3];
    int         b2b_lat [3];

    initial begin
        int cyc;
        n_total    = 0;
        n_bad      = 0;
        sel        = 1'b0;
        rst_n      = 1'b0;
        in_valid0  = 1'b0; in_value0 = 8'h00; out_ready0 = 1'b0;
        in_valid1  = 1'b0; in_value1 = 8'h00; out_ready1 = 1'b0;

        #3;
        check_val("rst_ready", {31'd0, in_ready0}, 32'd1);
        check_val("rst_valid", {31'd0, out_valid0}, 32'd0);
        check_val("rst_busy", {31'd0, busy0}, 32'd0);
        check_val("rst_hit", {31'd0, out_hit0}, 32'd0);
        check_val("rst_index", {29'd0, out_index0}, 32'd0);
        #9;
        rst_n = 1'b1;

        // First-match, early exit
        run_req(1'b0, 8'h00, 1'b1, 3'd0, 1, 0);
        run_req(1'b0, 8'hE2, 1'b1, 3'd3, 4, 5);
        run_req(1'b0, 8'h05, 1'b0, 3'd0, 8, 1);
        run_req(1'b0, 8'h01, 1'b1, 3'd1, 2, 0);
        run_req(1'b0, 8'h1E, 1'b1, 3'd2, 3, 2);

        // Constant-latency full scan
        run_req(1'b1, 8'h1E, 1'b1, 3'd2, 8, 0);
        run_req(1'b1, 8'h00, 1'b1, 3'd0, 8, 1);
        run_req(1'b1, 8'hE2, 1'b1, 3'd3, 8, 0);
        run_req(1'b1, 8'h05, 1'b0, 3'd0, 8, 0);

        // Reset in the middle of a search aborts it
        @(negedge clk);
        sel = 1'b0;
        drive_req(1'b0, 1'b1, 8'h05);
        @(posedge clk);
        #1;
        drive_req(1'b0, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("abort_valid", {31'd0, out_valid0}, 32'd0);
        check_val("abort_ready", {31'd0, in_ready0}, 32'd1);
        check_val("abort_busy", {31'd0, busy0}, 32'd0);
        check_val("abort_hit", {31'd0, out_hit0}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("abort_no_result", {31'd0, out_valid0}, 32'd0);
        run_req(1'b0, 8'h01, 1'b1, 3'd1, 2, 0);

        // Back-to-back with in_valid and out_ready held high
        b2b_val[0] = 8'h1E; b2b_hit[0] = 1'b1; b2b_idx[0] = 3'd2; b2b_lat[0] = 3;
        b2b_val[1] = 8'h05; b2b_hit[1] = 1'b0; b2b_idx[1] = 3'd0; b2b_lat[1] = 8;
        b2b_val[2] = 8'h01; b2b_hit[2] = 1'b1; b2b_idx[2] = 3'd1; b2b_lat[2] = 2;
        @(negedge clk);
        sel        = 1'b0;
        in_valid0  = 1'b1;
        in_value0  = b2b_val[0];
        out_ready0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val("b2b_ready_low", {31'd0, in_ready0}, 32'd0);
            cyc = 0;
            while (cyc < 20) begin
                @(posedge clk);
                #1;
                cyc++;
                if (out_valid0) break;
                check_val("b2b_ready_search", {31'd0, in_ready0}, 32'd0);
            end
            check_val("b2b_latency", cyc, b2b_lat[i]);
            check_val("b2b_hit", {31'd0, out_hit0}, {31'd0, b2b_hit[i]});
            check_val("b2b_index", {29'd0, out_index0}, {29'd0, b2b_idx[i]});
            @(posedge clk);
            #1;
            check_val("b2b_idle_valid", {31'd0, out_valid0}, 32'd0);
            check_val("b2b_idle_ready", {31'd0, in_ready0}, 32'd1);
            if (i < 2) in_value0 = b2b_val[i+1];
            else       in_valid0 = 1'b0;
        end
        out_ready0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("final_idle", {31'd0, busy0}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
